// File: rtl/dot4_host_driver_pkg.sv
// Shared types and constants for the dot4 accelerator host driver.
// States, accelerator mode encodings and the calibration vector.
package dot4_host_driver_pkg;

    typedef enum logic [2:0] {
        ST_CAL_START,
        ST_IDLE,
        ST_LOAD_D,
        ST_LOAD_W,
        ST_SETTLE,
        ST_CAP0,
        ST_CAP1,
        ST_RESP
    } state_t;

    typedef logic [7:0] byte_t;

    localparam logic [1:0] MODE_DATA = 2'b00;
    localparam logic [1:0] MODE_WGT  = 2'b11;
    localparam logic [1:0] MODE_HOLD = 2'b10;
    localparam logic [1:0] MODE_IDLE = 2'b01;

    // Element 0 = 1, elements 3..1 = 0, for both data and weights.
    localparam logic [27:0] CAL_DATA   = 28'h000_0001;
    localparam logic [27:0] CAL_WGT    = 28'h000_0001;
    localparam logic [15:0] CAL_EXPECT = 16'h0001;
    localparam byte_t       CAL_B_LO   = CAL_EXPECT[7:0];
    localparam byte_t       CAL_B_HI   = CAL_EXPECT[15:8];

    // Pick 7-bit element k out of a packed 4-element word.
    function automatic logic [6:0] elem(
        input logic [27:0] v,
        input logic [1:0]  k
    );
        logic [6:0] e;
        unique case (k)
            2'd0: e = v[6:0];
            2'd1: e = v[13:7];
            2'd2: e = v[20:14];
            2'd3: e = v[27:21];
        endcase
        return e;
    endfunction

endpackage

// File: rtl/dot4_byte_merge.sv
// Byte reassembly for the accelerator's alternating byte output.
// The toggle phase seen in calibration decides which capture is the low byte.
module dot4_byte_merge
    import dot4_host_driver_pkg::*;
(
    input  logic        ph0_i,
    input  logic        cal_ph_i,
    input  byte_t       b0_i,
    input  byte_t       b1_i,
    output logic [15:0] result_o
);

    assign result_o = (ph0_i == cal_ph_i) ? {b1_i, b0_i}
                                          : {b0_i, b1_i};

endmodule

// File: rtl/dot4_host_driver.sv
// Host-side driver for a 4-element 7-bit dot-product accelerator.
// Shifts operands in, captures two result bytes, reorders them by phase.
module dot4_host_driver #(
    parameter int SETTLE = 2,
    parameter bit CAL_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [27:0] in_data,
    input  logic [27:0] in_weights,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic [6:0]  acc_din,
    output logic [1:0]  acc_mode,
    input  logic [7:0]  acc_dout,
    output logic        cal_done,
    output logic        cal_err
);
    import dot4_host_driver_pkg::*;

    localparam int CW = 8;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

    state_t       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [27:0]  data_q, data_d;
    logic [27:0]  wgt_q, wgt_d;
    byte_t        b0_q, b0_d;
    logic         ph_q;
    logic         ph0_q, ph0_d;
    logic         cal_ph_q, cal_ph_d;
    logic         cal_done_q, cal_done_d;
    logic         cal_err_q, cal_err_d;
    logic         cal_q, cal_d;
    logic [15:0]  res_q, res_d;
    logic [15:0]  merged;

    dot4_byte_merge u_merge (
        .ph0_i    (ph0_q),
        .cal_ph_i (cal_ph_q),
        .b0_i     (b0_q),
        .b1_i     (acc_dout),
        .result_o (merged)
    );

    assign out_result = res_q;
    assign cal_done   = cal_done_q;
    assign cal_err    = cal_err_q;

    // State and datapath registers; ph free-runs to track the accel toggle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if (CAL_EN) state_q <= ST_CAL_START;
            else        state_q <= ST_IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            wgt_q      <= '0;
            b0_q       <= '0;
            ph_q       <= 1'b0;
            ph0_q      <= 1'b0;
            cal_ph_q   <= 1'b0;
            cal_done_q <= 1'b0;
            cal_err_q  <= 1'b0;
            cal_q      <= 1'b0;
            res_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            wgt_q      <= wgt_d;
            b0_q       <= b0_d;
            ph_q       <= ~ph_q;
            ph0_q      <= ph0_d;
            cal_ph_q   <= cal_ph_d;
            cal_done_q <= cal_done_d;
            cal_err_q  <= cal_err_d;
            cal_q      <= cal_d;
            res_q      <= res_d;
        end
    end

    // Next-state, sequencing and accelerator drive.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        wgt_d      = wgt_q;
        b0_d       = b0_q;
        ph0_d      = ph0_q;
        cal_ph_d   = cal_ph_q;
        cal_done_d = cal_done_q;
        cal_err_d  = cal_err_q;
        cal_d      = cal_q;
        res_d      = res_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        acc_din    = '0;
        acc_mode   = MODE_IDLE;

        unique case (state_q)
            ST_CAL_START: begin
                data_d  = CAL_DATA;
                wgt_d   = CAL_WGT;
                cal_d   = 1'b1;
                cnt_d   = '0;
                state_d = ST_LOAD_D;
            end
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = in_data;
                    wgt_d   = in_weights;
                    cal_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_LOAD_D;
                end
            end
            ST_LOAD_D: begin
                acc_mode = MODE_DATA;
                acc_din  = elem(data_q, 2'd3 - cnt_q[1:0]);
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(3)) begin
                    cnt_d   = '0;
                    state_d = ST_LOAD_W;
                end
            end
            ST_LOAD_W: begin
                acc_mode = MODE_WGT;
                acc_din  = elem(wgt_q, 2'd3 - cnt_q[1:0]);
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(3)) begin
                    cnt_d   = '0;
                    state_d = (SETTLE == 0) ? ST_CAP0 : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                acc_mode = MODE_HOLD;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_CAP0;
                end
            end
            ST_CAP0: begin
                acc_mode = MODE_HOLD;
                b0_d     = acc_dout;
                ph0_d    = ph_q;
                state_d  = ST_CAP1;
            end
            ST_CAP1: begin
                acc_mode = MODE_HOLD;
                if (cal_q) begin
                    cal_d = 1'b0;
                    if (b0_q == CAL_B_LO && acc_dout == CAL_B_HI) begin
                        cal_ph_d   = ph0_q;
                        cal_done_d = 1'b1;
                        cal_err_d  = 1'b0;
                        state_d    = ST_IDLE;
                    end else if (b0_q == CAL_B_HI &&
                                 acc_dout == CAL_B_LO) begin
                        cal_ph_d   = ~ph0_q;
                        cal_done_d = 1'b1;
                        cal_err_d  = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        cal_err_d = 1'b1;
                        state_d   = ST_CAL_START;
                    end
                end else begin
                    res_d   = merged;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dot4_host_driver.sv
// Self-checking bench for dot4_host_driver with a behavioural accelerator.
// Accelerator byte toggle free-runs and is never reset.
module tb_dot4_host_driver;

    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [27:0] in_data = '0;
    logic [27:0] in_weights = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic [6:0]  acc_din;
    logic [1:0]  acc_mode;
    logic [7:0]  acc_dout;
    logic        cal_done;
    logic        cal_err;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dot4_host_driver #(.SETTLE(SETTLE), .CAL_EN(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_weights (in_weights),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .acc_din    (acc_din),
        .acc_mode   (acc_mode),
        .acc_dout   (acc_dout),
        .cal_done   (cal_done),
        .cal_err    (cal_err)
    );

    // Accelerator model: shift registers, product, alternating bytes.
    logic       tog = 1'b0;
    logic       phase_sel = 1'b0;
    logic       bad = 1'b0;
    logic [6:0] md [4] = '{default: '0};
    logic [6:0] mw [4] = '{default: '0};
    logic [15:0] prod;

    always @(posedge clk) begin
        tog <= ~tog;
        if (acc_mode == 2'b00) begin
            md[3] <= md[2]; md[2] <= md[1];
            md[1] <= md[0]; md[0] <= acc_din;
        end
        if (acc_mode == 2'b11) begin
            mw[3] <= mw[2]; mw[2] <= mw[1];
            mw[1] <= mw[0]; mw[0] <= acc_din;
        end
    end

    always_comb begin
        prod = '0;
        for (int i = 0; i < 4; i++)
            prod = prod + 16'(md[i]) * 16'(mw[i]);
    end

    assign acc_dout = bad ? 8'hFF :
                      ((tog ^ phase_sel) ? prod[15:8] : prod[7:0]);

    function automatic logic [27:0] pack4(int e0, int e1, int e2, int e3);
        return {7'(e3), 7'(e2), 7'(e1), 7'(e0)};
    endfunction

    function automatic logic [15:0] ref_dot(logic [27:0] d, logic [27:0] w);
        int s = 0;
        for (int k = 0; k < 4; k++)
            s += int'((d >> (7 * k)) & 28'h7F) * int'((w >> (7 * k)) & 28'h7F);
        return s[15:0];
    endfunction

    task automatic apply_reset(input bit phase);
        @(negedge clk);
        rst_n = 1'b0;
        phase_sel = phase;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic release_and_cal(input int budget, output int cyc,
                                   output bit ov);
        rst_n = 1'b1;
        cyc = 0;
        ov = 1'b0;
        while (!cal_done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (out_valid) ov = 1'b1;
        end
    endtask

    task automatic run_txn(input logic [27:0] d, input logic [27:0] w,
                           input int hold, output logic [15:0] res,
                           output int lat, output bit to, output bit stable);
        int n = 0;
        to = 1'b0; lat = 0; res = '0; stable = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data = d;
        in_weights = w;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            to = 1'b1;
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        while (!out_valid && lat < 60) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data = 28'($urandom);
            in_weights = 28'($urandom);
            if (in_ready) stable = 1'b0;
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        if (!out_valid) begin
            to = 1'b1;
            return;
        end
        res = out_result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!out_valid || out_result !== res || in_ready)
                stable = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int cyc;
        bit ov;
        apply_reset(1'b0);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_in_ready got %b want 0", in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid);
        end
        n_checks++;
        if (out_result !== 16'h0) begin
            n_fail++; $display("FAIL rst_result got %h want 0000", out_result);
        end
        n_checks++;
        if (acc_mode !== 2'b01 || acc_din !== 7'h0) begin
            n_fail++;
            $display("FAIL rst_acc got mode %b din %h want 01 00",
                     acc_mode, acc_din);
        end
        n_checks++;
        if (cal_done !== 1'b0 || cal_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_cal got done %b err %b want 0 0",
                     cal_done, cal_err);
        end
        release_and_cal(20, cyc, ov);
        n_checks++;
        if (cal_done !== 1'b1 || cal_err !== 1'b0) begin
            n_fail++;
            $display("FAIL cal_pass got done %b err %b cyc %0d want 1 0",
                     cal_done, cal_err, cyc);
        end
        n_checks++;
        if (ov !== 1'b0) begin
            n_fail++; $display("FAIL cal_no_valid got %b want 0", ov);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL cal_idle_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [15:0] res;
        int lat;
        bit to, st;
        run_txn(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 0, res, lat, to, st);
        n_checks++;
        if (to || res !== 16'h0046) begin
            n_fail++;
            $display("FAIL basic_result got %h to %b want 0046", res, to);
        end
        n_checks++;
        if (lat != 10 + SETTLE) begin
            n_fail++;
            $display("FAIL basic_latency got %0d want %0d", lat, 10 + SETTLE);
        end
        n_checks++;
        if (!st) begin
            n_fail++; $display("FAIL basic_busy_ready got 1 want 0");
        end
    endtask

    task automatic test_hold();
        logic [15:0] res;
        logic [15:0] exp;
        logic [27:0] d, w;
        int lat;
        bit to, st;
        d = pack4(100, 3, 77, 12);
        w = pack4(9, 120, 1, 64);
        exp = ref_dot(d, w);
        run_txn(d, w, 5, res, lat, to, st);
        n_checks++;
        if (to || res !== exp) begin
            n_fail++;
            $display("FAIL hold_result got %h to %b want %h", res, to, exp);
        end
        n_checks++;
        if (!st) begin
            n_fail++; $display("FAIL hold_stable got unstable want stable");
        end
    endtask

    task automatic test_max();
        logic [15:0] res;
        int lat, cyc;
        bit to, st, ov;
        for (int p = 0; p < 2; p++) begin
            apply_reset(1'(p));
            release_and_cal(20, cyc, ov);
            n_checks++;
            if (cal_done !== 1'b1 || ov) begin
                n_fail++;
                $display("FAIL max_cal ph %0d got done %b ov %b want 1 0",
                         p, cal_done, ov);
            end
            run_txn(pack4(127, 127, 127, 127), pack4(127, 127, 127, 127),
                    0, res, lat, to, st);
            n_checks++;
            if (to || res !== 16'hFC04) begin
                n_fail++;
                $display("FAIL max_result ph %0d got %h want fc04", p, res);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] res, exp;
        logic [27:0] d, w;
        int lat;
        bit to, st;
        for (int i = 0; i < 12; i++) begin
            d = 28'($urandom);
            w = 28'($urandom);
            if (i == 0) d = '0;
            exp = ref_dot(d, w);
            run_txn(d, w, $urandom_range(0, 2), res, lat, to, st);
            n_checks++;
            if (to || res !== exp || !st) begin
                n_fail++;
                $display("FAIL rand_%0d got %h to %b st %b want %h",
                         i, res, to, st, exp);
            end
        end
    endtask

    task automatic test_cal_err();
        logic [15:0] res;
        int n, lat;
        bit to, st;
        apply_reset(1'b0);
        bad = 1'b1;
        rst_n = 1'b1;
        n = 0;
        while (!cal_err && n < 40) begin
            @(negedge clk); n++;
        end
        n_checks++;
        if (cal_err !== 1'b1 || cal_done !== 1'b0) begin
            n_fail++;
            $display("FAIL calerr_set got err %b done %b want 1 0",
                     cal_err, cal_done);
        end
        n = 0;
        while (acc_mode !== 2'b00 && n < 5) begin
            @(negedge clk); n++;
        end
        n_checks++;
        if (acc_mode !== 2'b00) begin
            n_fail++;
            $display("FAIL calerr_retry got mode %b want 00", acc_mode);
        end
        bad = 1'b0;
        n = 0;
        while (!cal_done && n < 60) begin
            @(negedge clk); n++;
        end
        n_checks++;
        if (cal_done !== 1'b1 || cal_err !== 1'b0) begin
            n_fail++;
            $display("FAIL calerr_clear got done %b err %b want 1 0",
                     cal_done, cal_err);
        end
        run_txn(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 0, res, lat, to, st);
        n_checks++;
        if (to || res !== 16'h0046) begin
            n_fail++;
            $display("FAIL calerr_txn got %h want 0046", res);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] res;
        int n, lat, cyc;
        bit to, st, ov;
        @(negedge clk);
        in_valid = 1'b1;
        in_data = pack4(9, 9, 9, 9);
        in_weights = pack4(9, 9, 9, 9);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk); n++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (acc_mode !== 2'b11 && n < 20) begin
            @(negedge clk); n++;
        end
        n_checks++;
        if (acc_mode !== 2'b11) begin
            n_fail++;
            $display("FAIL mid_loadw got mode %b want 11", acc_mode);
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || acc_mode !== 2'b01) begin
            n_fail++;
            $display("FAIL mid_abort got ov %b mode %b want 0 01",
                     out_valid, acc_mode);
        end
        release_and_cal(20, cyc, ov);
        n_checks++;
        if (cal_done !== 1'b1 || ov) begin
            n_fail++;
            $display("FAIL mid_recal got done %b ov %b want 1 0",
                     cal_done, ov);
        end
        run_txn(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 0, res, lat, to, st);
        n_checks++;
        if (to || res !== 16'h0046) begin
            n_fail++;
            $display("FAIL mid_txn got %h want 0046", res);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_max();
        test_random();
        test_cal_err();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dot4_host_driver.md
DOT4_HOST_DRIVER -- requirements
Module: dot4_host_driver

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2: cycles acc_mode is held at 2'b10 after the last weight word before the first capture.
REQ-002 The block SHALL have parameter CAL_EN, default 1: 1 = run phase calibration after every reset, 0 = skip it and treat the low byte as first.
REQ-003 The block SHALL have port clk  in  1  clock.
REQ-004 The block SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port in_valid  in  1  request valid.
REQ-006 The block SHALL have port in_ready  out  1  request accepted when in_valid && in_ready.
REQ-007 The block SHALL have port in_data  in  28  four 7-bit unsigned data elements, element k = in_data[7k+6:7k].
REQ-008 The block SHALL have port in_weights  in  28  four 7-bit unsigned weights, same packing.
REQ-009 The block SHALL have port out_valid  out  1  result valid, held until out_ready.
REQ-010 The block SHALL have port out_ready  in  1  result consumer ready.
REQ-011 The block SHALL have port out_result  out  16  reassembled dot product.
REQ-012 The block SHALL have port acc_din  out  7  word to accelerator ui_in[6:0].
REQ-013 The block SHALL have port acc_mode  out  2  to accelerator uio_in[1:0]: 00 shift data, 11 shift weights, 10 read/hold, 01 idle.
REQ-014 The block SHALL have port acc_dout  in  8  accelerator byte output.
REQ-015 The block SHALL have ports cal_done and cal_err  out  1 each  calibration status.

Function
REQ-016 FSM states SHALL be CAL_START, IDLE, LOAD_D, LOAD_W, SETTLE, CAP0, CAP1, RESP.
REQ-017 in_ready SHALL be 1 only in IDLE; on a handshake in_data and in_weights SHALL be latched and the FSM SHALL enter LOAD_D.
REQ-018 LOAD_D SHALL last exactly 4 cycles with acc_mode=00, driving element 3, 2, 1, 0 in that order on acc_din.
REQ-019 LOAD_W SHALL follow for exactly 4 cycles with acc_mode=11, driving weights 3, 2, 1, 0 in that order.
REQ-020 SETTLE SHALL drive acc_mode=10 for SETTLE cycles; CAP0 and CAP1 SHALL keep acc_mode=10, and each SHALL register acc_dout as b0 and b1.
REQ-021 A 1-bit toggle ph SHALL invert every cycle; ph SHALL be sampled as ph0 in CAP0.
REQ-022 Reassembly: if ph0 == cal_ph then out_result = {b1,b0}, else out_result = {b0,b1}.
REQ-023 RESP SHALL assert out_valid with out_result stable; on out_ready the FSM SHALL return to IDLE; minimum request-to-out_valid latency is 10+SETTLE cycles.
REQ-024 Calibration (CAL_START, CAL_EN=1) SHALL run the load/settle/capture flow with data={0,0,0,1} and weights={0,0,0,1} (expected result 0x0001) without asserting out_valid.
REQ-025 Calibration: if b0=0x01 and b1=0x00, cal_ph SHALL be set to ph0; if b0=0x00 and b1=0x01, cal_ph SHALL be set to ~ph0; either way cal_done=1 and the FSM SHALL enter IDLE.
REQ-026 Calibration: any other byte pair SHALL set cal_err=1 and SHALL retry calibration; cal_err SHALL clear on the next successful calibration.
REQ-027 acc_mode SHALL be 01 and acc_din SHALL be 0 in IDLE and RESP.
REQ-028 in_valid and in_data changes outside IDLE SHALL be ignored.
REQ-029 The maximum result 4*127*127 = 64516 SHALL fit in 16 bits without saturation.

Reset
REQ-030 Reset SHALL drive state=CAL_START (or IDLE if CAL_EN=0), in_ready=0, out_valid=0, out_result=0, acc_din=0, acc_mode=01, ph=0, cal_ph=0, cal_done=0, cal_err=0.
REQ-031 Reset asserted mid-transaction SHALL abort it with no out_valid; because the accelerator's byte toggle is not reset, calibration SHALL re-run after every reset.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the acc_mode encodings, and the calibration vector constants.
REQ-033 One sub-module, dot4_byte_merge (ph/cal_ph compare plus byte swap), is natural; the rest SHALL be flat.

Verification
REQ-034 Test 1: reset with model toggle phase 0 -> calibration passes, cal_done=1 within 20 cycles.
REQ-035 Test 2: data={1,2,3,4}, weights={5,6,7,8} -> out_result=0x0046 (70).
REQ-036 Test 3: all elements 127 -> out_result=0xFC04 (64516), for both model toggle phases.
REQ-037 Test 4: out_ready held 0 for 5 cycles -> out_valid and out_result stable, in_ready=0 throughout.
REQ-038 Test 5: model returns 0xFF bytes during calibration -> cal_err=1 and retry; model fixed -> cal_err=0, cal_done=1.
REQ-039 Test 6: rst_n low during LOAD_W -> no out_valid, acc_mode=01; recalibration follows, then test 2 passes.
